// File: rtl/sel_stepper.sv
// sel_stepper: debounced next/prev push buttons step a 2-bit wrapping select, with a host load path.
module sel_stepper #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter logic [1:0] RESET_SEL = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic [1:0] sel,
  output logic       changed,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;
  localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);
  state_t state, state_n;
  logic [1:0] sync1, raw, cand, cand_n, sel_n;
  logic [15:0] cnt, cnt_n;
  logic step, done;
  assign done = cnt == LAST;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cand_n = cand;
    step = 1'b0;
    case (state)
      IDLE: if (raw != 2'b00) begin
        cand_n = raw;
        cnt_n = '0;
        state_n = PRESS;
      end
      PRESS: if (raw != cand) state_n = IDLE;
        else if (done) begin
          step = 1'b1;
          state_n = HELD;
        end else cnt_n = cnt + 16'd1;
      HELD: if (raw == 2'b00) begin
        cnt_n = '0;
        state_n = RELEASE;
      end
      RELEASE: if (raw != 2'b00) state_n = HELD;
        else if (done) state_n = IDLE;
        else cnt_n = cnt + 16'd1;
      default: state_n = IDLE;
    endcase
  end
  // Load overrides a step on the same edge; both buttons together never step.
  assign sel_n = load ? load_val
               : (step && cand != 2'b11) ? (cand[0] ? sel + 2'd1 : sel - 2'd1)
               : sel;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 2'b00;
      raw <= 2'b00;
      state <= IDLE;
      cnt <= '0;
      cand <= 2'b00;
      sel <= RESET_SEL;
      changed <= 1'b0;
      busy <= 1'b0;
    end else begin
      sync1 <= {btn_prev, btn_next};
      raw <= sync1;
      state <= state_n;
      cnt <= cnt_n;
      cand <= cand_n;
      sel <= sel_n;
      changed <= sel_n != sel;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_sel_stepper.sv
// tb_sel_stepper: directed stimulus with a stability-run model of the debounced select stepper.
module tb_sel_stepper;
  localparam int D = 4;
  logic clk = 0, rst = 0, btn_next = 0, btn_prev = 0, load = 0;
  logic [1:0] load_val = 2'd0;
  logic [1:0] sel;
  logic changed, busy;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  sel_stepper #(.DEBOUNCE_CYCLES(D), .RESET_SEL(2'd0)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
    .load(load), .load_val(load_val), .sel(sel), .changed(changed), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // A press is accepted once the synchronized pins show the same nonzero value for D+1 samples;
  // it is released once they show zero for D+1 samples.
  logic [1:0] m_q1, m_q2, m_rprev, m_sel;
  int m_run, run_n;
  logic m_locked, m_chg, m_busy, accept, unlock, locked_n;
  always_comb begin
    run_n = (m_q2 == m_rprev) ? m_run + 1 : 1;
    accept = !m_locked && m_q2 != 2'b00 && run_n == D + 1;
    unlock = m_locked && m_q2 == 2'b00 && run_n == D + 1;
    locked_n = accept | (m_locked & ~unlock);
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q1 <= 0; m_q2 <= 0; m_rprev <= 0; m_run <= 0;
      m_locked <= 0; m_sel <= 0; m_chg <= 0; m_busy <= 0;
    end else begin
      m_q1 <= {btn_prev, btn_next};
      m_q2 <= m_q1;
      m_rprev <= m_q2;
      m_run <= run_n;
      m_locked <= locked_n;
      m_busy <= locked_n || m_q2 != 2'b00;
      if (load) begin
        m_sel <= load_val;
        m_chg <= load_val != m_sel;
      end else if (accept && m_q2 != 2'b11) begin
        m_sel <= (m_q2 == 2'b01) ? m_sel + 2'd1 : m_sel - 2'd1;
        m_chg <= 1'b1;
      end else m_chg <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("sel", int'(sel), int'(m_sel));
    chk("changed", int'(changed), int'(m_chg));
    chk("busy", int'(busy), int'(m_busy));
  end

  task automatic press(input logic [1:0] pins, input int hi, input int lo,
                       output int chg_edge, output int chg_cnt, output bit busy_seen);
    @(negedge clk); #1;
    {btn_prev, btn_next} = pins;
    chg_edge = -1; chg_cnt = 0; busy_seen = 0;
    for (int k = 0; k < hi + lo; k++) begin
      @(posedge clk); #1;
      if (changed) begin
        if (chg_edge < 0) chg_edge = k;
        chg_cnt++;
      end
      busy_seen |= busy;
      if (k == hi - 1) {btn_prev, btn_next} = 2'b00;
    end
  endtask

  task automatic do_load(input logic [1:0] v);
    @(negedge clk); #1;
    load = 1; load_val = v;
    @(posedge clk); #1;
    load = 0;
  endtask

  int e, c;
  bit b;
  initial begin
    #1 rst = 1;
    #1;
    chk("async_reset_sel", int'(sel), 0);
    chk("async_reset_changed", int'(changed), 0);
    chk("async_reset_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst = 0;
    repeat (10) @(negedge clk);
    chk("idle_sel", int'(sel), 0);
    press(2'b01, 20, 20, e, c, b);
    chk("first_step_edge", e, 2 + D);
    chk("first_step_pulses", c, 1);
    chk("sel_after_press1", int'(sel), 1);
    for (int i = 0; i < 3; i++) begin
      press(2'b01, 20, 20, e, c, b);
      chk("sel_seq", int'(sel), (i + 2) % 4);
      chk("seq_pulses", c, 1);
    end
    press(2'b10, 2, 20, e, c, b);
    chk("glitch_pulses", c, 0);
    chk("glitch_sel", int'(sel), 0);
    press(2'b10, 10, 20, e, c, b);
    chk("prev_wrap_sel", int'(sel), 3);
    chk("prev_wrap_pulses", c, 1);
    chk("prev_step_edge", e, 2 + D);
    press(2'b11, 10, 20, e, c, b);
    chk("both_pulses", c, 0);
    chk("both_sel", int'(sel), 3);
    chk("both_busy_seen", int'(b), 1);
    do_load(2'd1);
    chk("load1_sel", int'(sel), 1);
    do_load(2'd2);
    chk("load2_sel", int'(sel), 2);
    chk("load2_changed", int'(changed), 1);
    do_load(2'd2);
    chk("load_same_sel", int'(sel), 2);
    chk("load_same_changed", int'(changed), 0);
    @(negedge clk); #1 btn_next = 1;
    repeat (2 + D) @(posedge clk);
    @(negedge clk); #1 load = 1; load_val = 2'd3;
    @(posedge clk); #1 load = 0;
    chk("load_on_step_sel", int'(sel), 3);
    chk("load_on_step_changed", int'(changed), 1);
    repeat (10) @(posedge clk); #1;
    chk("load_on_step_no_extra", int'(sel), 3);
    chk("load_on_step_held_busy", int'(busy), 1);
    btn_next = 0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1 btn_next = 1;
    repeat (5) @(posedge clk);
    @(negedge clk); #1 rst = 1;
    #1;
    chk("midpress_reset_sel", int'(sel), 0);
    chk("midpress_reset_busy", int'(busy), 0);
    @(negedge clk); #1 rst = 0;
    e = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (changed && e < 0) e = k;
    end
    chk("post_reset_step_edge", e, D + 2);
    chk("post_reset_sel", int'(sel), 1);
    btn_next = 0;
    repeat (20) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/sel_stepper.md
# sel_stepper

Generates the 2-bit mux select that the change detector and 4-way muxes consume, driven by two front-panel push buttons. Raw button pins are synchronized, debounced and edge-qualified; each accepted press steps the select by one position, either forward or backward, wrapping around at the ends. A one-cycle `changed` strobe accompanies every select update. A synchronous load path lets a host force a select value directly.

## Interface
- `DEBOUNCE_CYCLES`, default 16: stable-sample count required to accept a press or a release. Legal range is 1..65535.
- `RESET_SEL`, default 2'd0: value `sel` takes in reset.

- `clk`  in  1  system clock; all state on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `btn_next`  in  1  raw pin, asynchronous to `clk`, active-high; steps `sel` up by 1
- `btn_prev`  in  1  raw pin, asynchronous to `clk`, active-high; steps `sel` down by 1
- `load`  in  1  synchronous, active-high; forces `sel` to `load_val`
- `load_val`  in  2  value loaded when `load` is high
- `sel`  out  2  registered select value
- `changed`  out  1  registered; high for exactly one cycle when `sel` takes a new value
- `busy`  out  1  registered; high whenever the FSM is not in IDLE

## Operation
- **Reset:** asserting `rst` immediately produces the following, independent of `clk`:
  - `sel`=`RESET_SEL`, `changed`=0, `busy`=0.
  - FSM=IDLE, counter=0, all synchronizer flops=0.
  - Reset mid-press discards the press.
- **Synchronizer:** 2-flop chain per button, giving `raw`={prev_s,next_s}.
- **FSM states:**
  - IDLE: if `raw`≠0, capture `cand`=`raw`, counter=0, go to PRESS.
  - PRESS: if `raw`≠`cand`, go to IDLE with no step. Else, if counter==`DEBOUNCE_CYCLES`-1, perform the step and go to HELD. Otherwise counter+1.
  - HELD: wait for `raw`==0, then counter=0 and go to RELEASE. There is no auto-repeat.
  - RELEASE: if `raw`≠0, go back to HELD. If counter==`DEBOUNCE_CYCLES`-1, go to IDLE. Otherwise counter+1.
- **Step rules:**
  - `cand`=2'b01 (next): `sel`+1 mod 4.
  - `cand`=2'b10 (prev): `sel`−1 mod 4.
  - `cand`=2'b11 (both buttons): no step and no `changed`, but the FSM still moves through HELD and RELEASE.
  - Wrap: 3→0 on next, 0→3 on prev.
- **Load:**
  - `load`=1 writes `load_val` to `sel` on the next edge.
  - `changed`=1 only if `load_val`≠ the current `sel`.
  - Load does not alter FSM state.
  - **Simultaneous load and step:** load wins, the step is dropped, and the FSM still advances to HELD.
- `changed` is 0 in every cycle in which `sel` is not updated to a different value.

## Timing
- Edge 0 is the first rising edge at which a pin is sampled high, with the pin held stable afterwards. The sequence is:
  - Edge 1: `raw` goes high.
  - Edge 2: FSM enters PRESS with counter=0.
  - Edge 2+`DEBOUNCE_CYCLES`: `sel` updates and `changed` rises.
- `sel` and `changed` update on the same edge. `changed` falls on the following edge.
- Load latency is 1 edge. `load` is sampled at edge k; `sel` and `changed` are valid after edge k.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles (as seen at `raw`) produces no step.
- Minimum time between two accepted presses is about 2·`DEBOUNCE_CYCLES`+4 cycles.
- `busy`=1 from entry into PRESS until the FSM returns to IDLE.

## Test plan
- **Reset:** assert `rst` asynchronously between edges → `sel`=0 (`RESET_SEL`=0), `changed`=0, `busy`=0 with no clock edge required. Release `rst` and hold 10 cycles → outputs unchanged.
- **Clean next press:** `DEBOUNCE_CYCLES`=4, `btn_next` high from edge 0 for 20 cycles, then low for 20 cycles → `sel` goes 0→1 at edge 6, `changed` is high only in that cycle, `busy` falls 4 cycles after `raw` drops. Repeat 4 presses → `sel` sequence 1,2,3,0.
- **Prev wrap and glitch:** `sel`=0, `btn_prev` pulsed 2 cycles → no change. Then `btn_prev` held 10 cycles → `sel`=3, one `changed` pulse.
- **Both buttons:** `btn_next` and `btn_prev` rise on the same edge and are held 10 cycles → `sel` unchanged, `changed` never asserted, `busy` cycles normally.
- **Load:**
  - `load`=1 with `load_val`=2 while `sel`=1 → `sel`=2 and `changed`=1 after 1 edge.
  - `load_val`=2 again → `changed`=0.
  - `load` asserted on the step edge → `sel`=`load_val` and no extra step.
- **Reset mid-press:** assert `rst` at counter=2 of PRESS, release it, keep `btn_next` held → `sel`=0 after reset. Re-debounce and step occurs `DEBOUNCE_CYCLES`+2 edges after the release edge.
